// File: rtl/inst_timing_pkg.sv
// Shared 6502 timing definitions: addressing-mode classes, NMOS base cycle
// counts and the T-states in which penalty inputs are sampled.
package cpu6502_pkg;

   typedef enum logic [3:0] {
      IMP, IMM, ZP, ZPX, ZPY, ABS, ABX, ABY, IZX, IZY, REL, IND, STK
   } addr_mode_e;

   localparam logic [2:0] BASE_IMP     = 3'd2;
   localparam logic [2:0] BASE_ZP      = 3'd3;
   localparam logic [2:0] BASE_ZP_RMW  = 3'd5;
   localparam logic [2:0] BASE_ZPX     = 3'd4;
   localparam logic [2:0] BASE_ZPX_RMW = 3'd6;
   localparam logic [2:0] BASE_ABS     = 3'd4;
   localparam logic [2:0] BASE_JMP_ABS = 3'd3;
   localparam logic [2:0] BASE_ABS_RMW = 3'd6;
   localparam logic [2:0] BASE_ABX_RD  = 3'd4;
   localparam logic [2:0] BASE_ABX_ST  = 3'd5;
   localparam logic [2:0] BASE_ABX_RMW = 3'd7;
   localparam logic [2:0] BASE_IZX     = 3'd6;
   localparam logic [2:0] BASE_IZY_RD  = 3'd5;
   localparam logic [2:0] BASE_IZY_ST  = 3'd6;
   localparam logic [2:0] BASE_REL     = 3'd2;
   localparam logic [2:0] BASE_PUSH    = 3'd3;
   localparam logic [2:0] BASE_PULL    = 3'd4;
   localparam logic [2:0] BASE_SUB     = 3'd6;
   localparam logic [2:0] BASE_JMP_IND = 3'd5;
   localparam logic [2:0] BASE_BRK     = 3'd7;

   // T-state numbers (1 = T1) where each penalty input is meaningful
   localparam int PEN_REL_TAKEN = 2;
   localparam int PEN_REL_CROSS = 3;
   localparam int PEN_IDX       = 3;
   localparam int PEN_IZY       = 4;

endpackage

// File: rtl/inst_timing_if.sv
// Sequencer <-> instruction-timing bus: T-state/opcode inputs and the
// decoded classification plus next_sync returned to the sequencer.
interface inst_timing_if;
   logic [7:0]              data_in;
   logic [5:0]              cycle;
   logic                    sync;
   logic                    branch_taken;
   logic                    page_cross;
   logic                    next_sync;
   logic [7:0]              opcode;
   cpu6502_pkg::addr_mode_e mode;
   logic                    rmw;
   logic                    store;
   logic                    illegal;

   modport master (
      output data_in, cycle, sync, branch_taken, page_cross,
      input  next_sync, opcode, mode, rmw, store, illegal
   );

   modport slave (
      input  data_in, cycle, sync, branch_taken, page_cross,
      output next_sync, opcode, mode, rmw, store, illegal
   );
endinterface

// File: rtl/inst_timing_op_class_decode.sv
// Combinational opcode classifier (aaa-bbb-cc field decode).
// INST_TIMING_ILLEGAL_DET_EN exposes undocumented opcodes on `illegal`.
module op_class_decode
   import cpu6502_pkg::*;
(
   input  logic [7:0] opcode,
   output addr_mode_e mode,
   output logic [2:0] base,
   output logic       rmw,
   output logic       store,
   output logic       illegal
);
   logic [2:0] aaa, bbb;
   logic [1:0] cc;
   logic       mem_rmw, st, undoc;

   assign aaa     = opcode[7:5];
   assign bbb     = opcode[4:2];
   assign cc      = opcode[1:0];
   assign st      = (aaa == 3'd4);
   assign mem_rmw = (aaa[2:1] != 2'b10);

   always_comb begin
      mode  = IMP;
      base  = BASE_IMP;
      rmw   = 1'b0;
      store = 1'b0;
      undoc = 1'b0;
      case (cc)
         2'b01: begin
            store = st;
            case (bbb)
               3'd0: begin mode = IZX; base = BASE_IZX; end
               3'd1: begin mode = ZP;  base = BASE_ZP;  end
               3'd2: begin mode = IMM; undoc = st; end
               3'd3: begin mode = ABS; base = BASE_ABS; end
               3'd4: begin mode = IZY; base = st ? BASE_IZY_ST : BASE_IZY_RD; end
               3'd5: begin mode = ZPX; base = BASE_ZPX; end
               3'd6: begin mode = ABY; base = st ? BASE_ABX_ST : BASE_ABX_RD; end
               default: begin mode = ABX; base = st ? BASE_ABX_ST : BASE_ABX_RD; end
            endcase
         end
         2'b10: begin
            case (bbb)
               3'd0: if (aaa == 3'd5) mode = IMM; else undoc = 1'b1;
               3'd1: begin
                  mode = ZP; rmw = mem_rmw; store = st;
                  base = mem_rmw ? BASE_ZP_RMW : BASE_ZP;
               end
               3'd2: mode = IMP;
               3'd3: begin
                  mode = ABS; rmw = mem_rmw; store = st;
                  base = mem_rmw ? BASE_ABS_RMW : BASE_ABS;
               end
               3'd4: undoc = 1'b1;
               3'd5: begin
                  // STX/LDX index with Y in this column
                  rmw = mem_rmw; store = st;
                  mode = mem_rmw ? ZPX : ZPY;
                  base = mem_rmw ? BASE_ZPX_RMW : BASE_ZPX;
               end
               3'd6: undoc = mem_rmw;
               default: begin
                  if (aaa == 3'd4) undoc = 1'b1;
                  else if (aaa == 3'd5) begin mode = ABY; base = BASE_ABX_RD; end
                  else begin mode = ABX; base = BASE_ABX_RMW; rmw = 1'b1; end
               end
            endcase
         end
         2'b00: begin
            case (bbb)
               3'd0: begin
                  case (aaa)
                     3'd0: begin mode = STK; base = BASE_BRK; end
                     3'd1, 3'd2, 3'd3: begin mode = STK; base = BASE_SUB; end
                     3'd4: undoc = 1'b1;
                     default: mode = IMM;
                  endcase
               end
               3'd1: begin
                  if (aaa == 3'd0 || aaa == 3'd2 || aaa == 3'd3) undoc = 1'b1;
                  else begin mode = ZP; base = BASE_ZP; store = st; end
               end
               3'd2: if (!aaa[2]) begin
                  mode = STK;
                  base = aaa[0] ? BASE_PULL : BASE_PUSH;
               end
               3'd3: begin
                  case (aaa)
                     3'd0: undoc = 1'b1;
                     3'd2: begin mode = ABS; base = BASE_JMP_ABS; end
                     3'd3: begin mode = IND; base = BASE_JMP_IND; end
                     default: begin mode = ABS; base = BASE_ABS; store = st; end
                  endcase
               end
               3'd4: begin mode = REL; base = BASE_REL; end
               3'd5: begin
                  if (aaa[2:1] == 2'b10) begin mode = ZPX; base = BASE_ZPX; store = st; end
                  else undoc = 1'b1;
               end
               3'd6: mode = IMP;
               default: begin
                  if (aaa == 3'd5) begin mode = ABX; base = BASE_ABX_RD; end
                  else undoc = 1'b1;
               end
            endcase
         end
         default: undoc = 1'b1;
      endcase
      if (undoc) begin
         mode  = IMP;
         base  = BASE_IMP;
         rmw   = 1'b0;
         store = 1'b0;
      end
   end

`ifdef INST_TIMING_ILLEGAL_DET_EN
   assign illegal = undoc;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/inst_timing.sv
// Instruction-length controller: latches the opcode at T1 and raises next_sync
// in the final T-state, including branch/page-cross penalties and T7.
module inst_timing
   import cpu6502_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   inst_timing_if.slave bus
);
   typedef enum logic {START, RUN} state_e;

   state_e     state;
   logic [7:0] op_q;
   logic [1:0] extra;
   logic       t7;
   addr_mode_e mode;
   logic [2:0] base;
   logic       rmw, store, illegal;
   logic       penalty, ns;
   logic [3:0] fin;
   logic [2:0] fin_idx;

   op_class_decode u_dec (
      .opcode  (op_q),
      .mode    (mode),
      .base    (base),
      .rmw     (rmw),
      .store   (store),
      .illegal (illegal)
   );

   always_comb begin
      penalty = 1'b0;
      if (state == RUN) begin
         case (mode)
            REL: penalty = (bus.cycle[PEN_REL_TAKEN-1] & bus.branch_taken)
                         | (bus.cycle[PEN_REL_CROSS-1] & (extra != 2'd0) & bus.page_cross);
            ABX, ABY: penalty = ~store & ~rmw & bus.cycle[PEN_IDX-1] & bus.page_cross;
            IZY: penalty = ~store & bus.cycle[PEN_IZY-1] & bus.page_cross;
            default: penalty = 1'b0;
         endcase
      end
   end

   assign fin     = {1'b0, base} + {2'b00, extra} + {3'b000, penalty};
   assign fin_idx = fin[2:0] - 3'd1;

   always_comb begin
      ns = 1'b0;
      if (state == START) ns = 1'b1;
      // all-zero cycle is either the T7 slot or a lost sequencer: end it either way
      else if (bus.cycle == 6'd0) ns = 1'b1;
      else if (fin > 4'd6) ns = t7;
      else ns = bus.cycle[fin_idx];
   end

   assign bus.next_sync = rst_n & ns;
   assign bus.opcode    = op_q;
   assign bus.mode      = mode;
   assign bus.rmw       = rmw;
   assign bus.store     = store;
   assign bus.illegal   = illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= START;
         op_q  <= 8'hEA;
         extra <= 2'd0;
         t7    <= 1'b0;
      end else begin
         if (state == START) state <= RUN;
         if (bus.sync) begin
            op_q  <= bus.data_in;
            extra <= 2'd0;
            t7    <= 1'b0;
         end else begin
            if (penalty) extra <= extra + 2'd1;
            if (state == RUN && bus.cycle[5] && fin > 4'd6) t7 <= 1'b1;
            else if (bus.cycle == 6'd0) t7 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_timing.sv
// Self-checking bench for inst_timing: bench acts as the sequencer, a table
// model predicts each instruction's length, a monitor scores next_sync.
module tb_inst_timing;
   import cpu6502_pkg::*;

   typedef struct {
      logic [7:0] op;
      int         len;
      logic       ill;
      logic       st;
      logic       rw;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t m_e;
   int   m_t;

   inst_timing_if bus ();

   inst_timing dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // NMOS cycle table written from opcode lists; penalty bits indexed by T-state
   function automatic exp_t model(input logic [7:0] op, input logic [7:0] btv,
                                  input logic [7:0] pcv);
      exp_t e;
      e.op = op; e.len = 2; e.ill = 1'b0; e.st = 1'b0; e.rw = 1'b0;
      case (op)
         8'h00: e.len = 7;
         8'h20, 8'h40, 8'h60: e.len = 6;
         8'h08, 8'h48, 8'h4C: e.len = 3;
         8'h28, 8'h68: e.len = 4;
         8'h6C: e.len = 5;
         8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
            e.len = 2 + int'(btv[2]) + int'(btv[2] & pcv[3]);
         8'h01, 8'h21, 8'h41, 8'h61, 8'hA1, 8'hC1, 8'hE1: e.len = 6;
         8'h81: begin e.len = 6; e.st = 1'b1; end
         8'h11, 8'h31, 8'h51, 8'h71, 8'hB1, 8'hD1, 8'hF1: e.len = 5 + int'(pcv[4]);
         8'h91: begin e.len = 6; e.st = 1'b1; end
         8'h19, 8'h39, 8'h59, 8'h79, 8'hB9, 8'hD9, 8'hF9,
         8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'hBD, 8'hDD, 8'hFD, 8'hBC, 8'hBE:
            e.len = 4 + int'(pcv[3]);
         8'h99, 8'h9D: begin e.len = 5; e.st = 1'b1; end
         8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE: begin e.len = 7; e.rw = 1'b1; end
         8'h05, 8'h25, 8'h45, 8'h65, 8'hA5, 8'hC5, 8'hE5,
         8'h24, 8'hA4, 8'hC4, 8'hE4, 8'hA6: e.len = 3;
         8'h85, 8'h84, 8'h86: begin e.len = 3; e.st = 1'b1; end
         8'h06, 8'h26, 8'h46, 8'h66, 8'hC6, 8'hE6: begin e.len = 5; e.rw = 1'b1; end
         8'h15, 8'h35, 8'h55, 8'h75, 8'hB5, 8'hD5, 8'hF5, 8'hB4, 8'hB6: e.len = 4;
         8'h95, 8'h94, 8'h96: begin e.len = 4; e.st = 1'b1; end
         8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6: begin e.len = 6; e.rw = 1'b1; end
         8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'hAD, 8'hCD, 8'hED,
         8'h2C, 8'hAC, 8'hCC, 8'hEC, 8'hAE: e.len = 4;
         8'h8D, 8'h8C, 8'h8E: begin e.len = 4; e.st = 1'b1; end
         8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'hCE, 8'hEE: begin e.len = 6; e.rw = 1'b1; end
         8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9, 8'hA0, 8'hA2, 8'hC0, 8'hE0,
         8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'h8A, 8'hAA, 8'hCA, 8'hEA, 8'h9A, 8'hBA,
         8'h88, 8'hA8, 8'hC8, 8'hE8,
         8'h18, 8'h38, 8'h58, 8'h78, 8'h98, 8'hB8, 8'hD8, 8'hF8: e.len = 2;
         default: begin
            e.len = 2;
`ifdef INST_TIMING_ILLEGAL_DET_EN
            e.ill = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   // Act as the sequencer: T1..T6 then all-zero T7, stopping when next_sync is seen
   task automatic run_instr(input logic [7:0] op, input logic [7:0] btv,
                            input logic [7:0] pcv);
      int   t;
      logic done;
      exp_q.push_back(model(op, btv, pcv));
      t = 1; done = 1'b0;
      bus.sync = 1'b1; bus.data_in = op; bus.cycle = 6'b000001;
      bus.branch_taken = btv[1]; bus.page_cross = pcv[1];
      while (!done) begin
         @(negedge clk);
         done = bus.next_sync;
         if (!done && t == 7) begin
            chk("next_sync_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (!done) begin
            t++;
            bus.sync = 1'b0;
            bus.data_in = 8'($urandom);
            bus.cycle = (t <= 6) ? 6'(1 << (t - 1)) : 6'd0;
            bus.branch_taken = btv[t];
            bus.page_cross = pcv[t];
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_opcode"}, int'(bus.opcode), 8'hEA);
      chk({tag, "_mode"}, int'(bus.mode), int'(IMP));
      chk({tag, "_rmw"}, int'(bus.rmw), 0);
      chk({tag, "_store"}, int'(bus.store), 0);
      chk({tag, "_illegal"}, int'(bus.illegal), 0);
      chk({tag, "_next_sync"}, int'(bus.next_sync), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.next_sync && exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         m_t = 7;
         for (int i = 0; i < 6; i++) if (bus.cycle[i]) m_t = i + 1;
         chk($sformatf("len_%02h", m_e.op), m_t, m_e.len);
         chk($sformatf("opcode_%02h", m_e.op), int'(bus.opcode), int'(m_e.op));
         chk($sformatf("illegal_%02h", m_e.op), int'(bus.illegal), int'(m_e.ill));
         chk($sformatf("store_%02h", m_e.op), int'(bus.store), int'(m_e.st));
         chk($sformatf("rmw_%02h", m_e.op), int'(bus.rmw), int'(m_e.rw));
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.sync = 1'b0; bus.cycle = 6'd0; bus.data_in = 8'h00;
      bus.branch_taken = 1'b0; bus.page_cross = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst_n = 1'b1;
      @(negedge clk);
      chk("start_pulse", int'(bus.next_sync), 1);
      @(posedge clk); #1;

      run_instr(8'hEA, 8'h00, 8'h00);
      run_instr(8'hBD, 8'h00, 8'h00);
      run_instr(8'hBD, 8'h00, 8'h08);
      run_instr(8'hBD, 8'h00, 8'hF7);
      run_instr(8'hD0, 8'h00, 8'hFF);
      run_instr(8'hD0, 8'h04, 8'h00);
      run_instr(8'hD0, 8'h04, 8'h08);
      run_instr(8'hD0, 8'hFB, 8'hFF);
      run_instr(8'hFE, 8'hFF, 8'hFF);
      run_instr(8'h00, 8'hFF, 8'hFF);
      run_instr(8'h91, 8'h00, 8'h10);
      run_instr(8'hB1, 8'h00, 8'h10);
      run_instr(8'h02, 8'hFF, 8'hFF);
      run_instr(8'hA9, 8'h00, 8'h00);

      // JSR aborted by reset in T3
      bus.sync = 1'b1; bus.data_in = 8'h20; bus.cycle = 6'b000001;
      @(posedge clk); #1;
      bus.sync = 1'b0; bus.cycle = 6'b000010;
      @(posedge clk); #1;
      bus.cycle = 6'b000100;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1; bus.cycle = 6'd0;
      @(negedge clk);
      chk("start_after_rst", int'(bus.next_sync), 1);
      @(posedge clk); #1;
      run_instr(8'hEA, 8'h00, 8'h00);

      for (int k = 0; k < 300; k++)
         run_instr(8'($urandom_range(255)), 8'($urandom), 8'($urandom));

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_timing.md
# inst_timing

Instruction-length controller for the 6502 core, sitting directly upstream of the one-hot cycle sequencer. It latches the opcode during the sync (T1) cycle and classifies its addressing mode. It then watches the sequencer's one-hot `cycle` and drives `next_sync` in the final cycle of every instruction, including page-cross and taken-branch penalty cycles and 7-cycle instructions.

## Interface
Parameters:
- none. All cycle counts are fixed constants in the shared package.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  data-bus read value; holds the opcode while `sync`=1.
- `cycle`  in  6  one-hot T-state from the sequencer (bit0=T1 … bit5=T6); all-zero after T6.
- `sync`  in  1  sequencer opcode-fetch flag (T1).
- `branch_taken`  in  1  branch condition true; valid in T2 of relative instructions.
- `page_cross`  in  1  index/branch add carried into the high byte; valid in the penalty-sampling cycle.
- `next_sync`  out  1  this is the last cycle of the instruction; the sequencer enters T1 next clock.
- `opcode`  out  8  latched opcode.
- `mode`  out  4  addressing-mode class (package enum).
- `rmw`  out  1  opcode is read-modify-write.
- `store`  out  1  opcode is a store.
- `illegal`  out  1  undocumented opcode (see Configuration).

## Operation
- FSM states: START, RUN.
  - START: entered on reset. `next_sync`=1 for exactly one cycle, then RUN.
  - RUN: normal operation; there is no path back to START except reset.
- Opcode capture: at the rising edge ending a cycle with `sync`=1, register `opcode`<=`data_in`. `mode`, `rmw`, `store` and `illegal` are decoded from the registered opcode. The penalty count `extra` (2 bits) and `t7` are cleared at the same edge.
- Base cycle counts (NMOS table):
  - implied/accumulator/immediate: 2
  - zp: 3; zp RMW: 5
  - zp,X / zp,Y: 4; RMW: 6
  - abs: 4; JMP abs: 3; abs RMW: 6
  - abs,X / abs,Y: read 4, store 5, RMW 7
  - (zp,X): 6
  - (zp),Y: read 5, store 6
  - relative: 2
  - PHA/PHP: 3; PLA/PLP: 4
  - JSR/RTS/RTI: 6; JMP (ind): 5; BRK: 7
- Penalties. Only reads and relative instructions take penalties; stores and RMW never do.
  - Relative, T2: `branch_taken` adds 1.
  - Relative, T3: `page_cross` adds 1, counted only if the branch was taken.
  - abs,X/Y read, T3: `page_cross` adds 1.
  - (zp),Y read, T4: `page_cross` adds 1.
- Final cycle F = base + `extra`, where `extra` includes the current cycle's penalty combinationally.
- `next_sync` = `cycle`[F-1] for F≤6. For F=7, `next_sync` = `t7`.
- `t7` is a registered flag, set at the edge ending T6 when F>6. It covers the all-zero `cycle` state after T6.

## Timing
- `next_sync` is combinational from registered state plus `cycle`, `branch_taken` and `page_cross`. It has no register of its own.
- Minimum instruction length is 2, so the opcode is always registered before `next_sync` can depend on it.
- Reset values: `opcode`=8'hEA, `mode`=IMP, `rmw`=0, `store`=0, `illegal`=0, `extra`=0, `t7`=0, state=START. `next_sync`=0 while `rst_n`=0.
- Reset mid-instruction: abort immediately (asynchronous). The first cycle after release is START.
- `cycle` all-zero with `t7`=0 in RUN is a protocol error. `next_sync` is held 1 to resynchronize.
- `sync`=1 together with `next_sync`=1 is legal, for example a 2-cycle instruction following START.

## Configuration
- Macro: `INST_TIMING_ILLEGAL_DET_EN`.
- Defined: undocumented opcodes decode to implied with base 2. `illegal`=1 while that opcode is held.
- Undefined: `illegal` is tied 0. Undocumented opcodes still time as 2-cycle implied.

## Structure
- Package `cpu6502_pkg` holds:
  - the addressing-mode enum (IMP, IMM, ZP, ZPX, ZPY, ABS, ABX, ABY, IZX, IZY, REL, IND, STK);
  - base-cycle constants;
  - penalty sampling-cycle constants.
- Sub-module `op_class_decode`: combinational opcode → {mode, base, rmw, store, illegal}. The FSM, `extra` and `t7` live in the top level.

## Test plan
- Reset release: `next_sync`=1 for exactly one cycle, then feed 8'hEA at T1 → `next_sync` high at T2, `opcode`=8'hEA.
- LDA abs,X (8'hBD) with `page_cross`=0 → `next_sync` at T4. With `page_cross`=1 at T3 → `next_sync` at T5.
- BNE (8'hD0): not taken → T2. Taken, no cross → T3. Taken with `page_cross`=1 at T3 → T4.
- INC abs,X (8'hFE) with `page_cross`=1 → `next_sync` at the all-zero cycle after T6 (T7). Same for BRK (8'h00).
- STA (zp),Y (8'h91) with `page_cross`=1 at T4 → `next_sync` still at T6, no penalty.
- `rst_n` pulsed low during T3 of JSR (8'h20) → outputs at reset values, then START behaviour. Also check 8'h02: with the macro defined `illegal`=1 and `next_sync` at T2; without it `illegal`=0.
